demux1_16_seq: RTL and testbench
================================

# demux1_16_seq

Registered 1-to-16 demultiplexer: routes a single-bit data stream onto 16 held output lanes, either to an addressed lane or by auto-scanning lanes 0..15. It is the receiving end of the 16:1 selection path: whatever a 16:1 mux serialises by stepping its select, this block scatters back into a parallel word and flags each completed frame. It sits between the serial link and the parallel consumer logic.

## Interface

**Parameters**
- `N_LANES`, default 16: number of output lanes. Must be a power of two.
- `SEL_W`, default 4: select and index width; equals log2(`N_LANES`).

**Ports**
- `clk`, in, 1: the single clock; everything is rising-edge.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `din`, in, 1: serial data bit.
- `din_valid`, in, 1: `din` is valid this cycle (one beat).
- `mode`, in, 1: 0 = addressed mode; 1 = scan mode.
- `sel`, in, `SEL_W`: target lane in addressed mode.
- `start`, in, 1: in scan mode, begin a frame.
- `clr`, in, 1: synchronous clear of the lanes, and abort of any frame.
- `q`, out, `N_LANES`: registered lane values.
- `idx`, out, `SEL_W`: current scan index.
- `busy`, out, 1: high while a scan frame is in progress.
- `frame_valid`, out, 1: one-cycle pulse when a scan frame completes.
- `ack`, out, 1: one-cycle pulse confirming an addressed write.

## Operation

**Priority, highest first:** `rst_n` low, then `clr`, then normal operation.

**Reset** (`rst_n` low at the clock edge):
- `q` = 0, `idx` = 0, `busy` = 0, `frame_valid` = 0, `ack` = 0.
- State = IDLE. This applies mid-frame too; the partial frame is discarded.

**`clr` high:**
- `q` = 0, `idx` = 0, state = IDLE.
- `frame_valid` and `ack` = 0 that cycle.
- Any beat in the same cycle is dropped.

**State machine (IDLE, SCAN, DONE):**
- **IDLE, addressed mode** (`mode` = 0, `din_valid` = 1):
  - `q[sel]` <= `din`; all other lanes hold.
  - `ack` <= 1 for one cycle.
  - `start` is ignored in this mode.
- **IDLE, scan mode** (`mode` = 1, `start` = 1): go to SCAN; `idx` <= 0; `busy` <= 1.
  - `din_valid` in the same cycle as `start` is not captured. The first beat is taken no earlier than the next cycle.
- **SCAN**, on each `din_valid`:
  - `q[idx]` <= `din`; other lanes hold.
  - If `idx` == `N_LANES`-1: go to DONE and wrap `idx` to 0. Otherwise `idx` <= `idx` + 1.
  - Cycles without `din_valid` hold state and `idx`; there is no timeout.
  - `start`, `sel` and `mode` changes are ignored while in SCAN.
- **DONE:** `frame_valid` = 1 and `busy` = 0 for exactly this cycle, then IDLE unconditionally.
  - A beat arriving in DONE is dropped.
  - `start` in DONE is ignored. A new frame needs `start` in IDLE.

**Width rules:**
- `idx` increments modulo `N_LANES`.
- `sel` is always in range, since its width equals log2(`N_LANES`).

## Timing

- **Write latency:** `q` reflects a captured beat one cycle after the edge at which `din_valid` was sampled.
- **`ack`:** asserted in the same cycle that `q` is updated.
- **`frame_valid`:** rises on the cycle after the 16th beat's edge. At that point `q` already holds the complete frame.
- **Minimum frame duration:** 1 `start` cycle + 16 beat cycles + 1 DONE cycle = 18 cycles.
- **Outputs:** all outputs are registered; there are no combinational paths from input to output.

## Structure

- **Shared package `demux_pkg`:**
  - State encoding `demux_state_t`: IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10.
  - Mode constants `MODE_ADDR` = 0 and `MODE_SCAN` = 1.
- **Sub-module `dec4_16`:** a combinational one-hot decoder (`SEL_W` in, `N_LANES` out) producing the lane write-enable. Its input is muxed between `sel` and `idx` depending on state.
- **Top level:** state register, index counter, lane register bank, and `ack`/`frame_valid` pulse registers.

## Test plan

- **Reset:** hold `rst_n` = 0 for 2 cycles with `din_valid` = 1 and `din` = 1.
  - Expect `q` = 16'h0000, `idx` = 0, `busy` = 0, and no pulses.
- **Addressed writes:** `mode` = 0; write 1 to `sel` = 3, then `sel` = 12, then 0 to `sel` = 3.
  - Expect `q` = 16'h0008, then 16'h1008, then 16'h1000.
  - Expect `ack` high 1 cycle after each write.
- **Scan frame:** `mode` = 1, `start`, then 16 consecutive beats carrying 16'hA5C3, LSB first.
  - Expect `q` = 16'hA5C3 and `frame_valid` = 1 on the cycle after beat 16.
  - Expect `busy` low from that cycle on.
- **Gapped scan:** same frame with `din_valid` gaps of 0 to 3 cycles between beats.
  - Expect the identical `q`; `idx` holds during gaps.
- **Abort:**
  - Start a scan, send 7 beats, then assert `clr` together with a beat. Expect `q` = 0, `idx` = 0, IDLE, no `frame_valid`.
  - Repeat using `rst_n` low instead of `clr`; expect the same result.
- **Ignored inputs:**
  - `start` in SCAN and in DONE: no restart.
  - `sel` changes in SCAN: no effect on which lane is written.
  - Beat during DONE: `q` unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-16 demultiplexer:
// FSM state encoding and the mode input constants.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } demux_state_t;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/demux1_16_seq_dec4_16.sv
// Combinational one-hot decoder turning a lane index into the lane
// write-enable vector.
module dec4_16 #(
  parameter int N_LANES = 16,
  parameter int SEL_W   = 4
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [N_LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_LANES; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux1_16_seq.sv
// Registered 1-to-16 demultiplexer: scatters a serial bit stream onto held
// output lanes, either to an addressed lane or by scanning a full frame.
module demux1_16_seq
  import demux_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               start,
  input  logic               clr,
  output logic [N_LANES-1:0] q,
  output logic [SEL_W-1:0]   idx,
  output logic               busy,
  output logic               frame_valid,
  output logic               ack
);

  // din_valid qualifies din for exactly one cycle; there is no back-pressure,
  // so a beat that arrives while the block cannot take it is simply dropped.

  demux_state_t       state_q, state_d;
  logic [N_LANES-1:0] q_q, q_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               frame_valid_q, frame_valid_d;
  logic               ack_q, ack_d;

  logic [SEL_W-1:0]   dec_sel;
  logic [N_LANES-1:0] lane_we;
  logic [N_LANES-1:0] q_written;

  // During a scan the counter owns the decoder; otherwise the address does.
  assign dec_sel = (state_q == SCAN) ? idx_q : sel;

  dec4_16 #(
    .N_LANES(N_LANES),
    .SEL_W  (SEL_W)
  ) u_dec (
    .sel   (dec_sel),
    .onehot(lane_we)
  );

  assign q_written = din ? (q_q | lane_we) : (q_q & ~lane_we);

  always_comb begin
    state_d       = state_q;
    q_d           = q_q;
    idx_d         = idx_q;
    busy_d        = busy_q;
    frame_valid_d = 1'b0;
    ack_d         = 1'b0;

    if (clr) begin
      state_d = IDLE;
      q_d     = '0;
      idx_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode == MODE_ADDR) begin
            if (din_valid) begin
              q_d   = q_written;
              ack_d = 1'b1;
            end
          end else if (start) begin
            state_d = SCAN;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end
        SCAN: begin
          if (din_valid) begin
            q_d = q_written;
            if (idx_q == SEL_W'(N_LANES - 1)) begin
              state_d       = DONE;
              idx_d         = '0;
              busy_d        = 1'b0;
              frame_valid_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      q_q           <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      ack_q         <= ack_d;
    end
  end

  assign q           = q_q;
  assign idx         = idx_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign ack         = ack_q;

endmodule

// File: tb/tb_demux1_16_seq.sv
// Self-checking bench for demux1_16_seq: a table of single-cycle vectors,
// then hand-written scan frame, gapped frame, noisy frame and abort sequences.
module tb_demux1_16_seq;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        mode;
  logic [3:0]  sel;
  logic        start;
  logic        clr;
  logic [15:0] q;
  logic [3:0]  idx;
  logic        busy;
  logic        frame_valid;
  logic        ack;

  int tests_run;
  int tests_failed;

  logic [15:0] exp_q[$];

  demux1_16_seq #(
    .N_LANES(16),
    .SEL_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .mode       (mode),
    .sel        (sel),
    .start      (start),
    .clr        (clr),
    .q          (q),
    .idx        (idx),
    .busy       (busy),
    .frame_valid(frame_valid),
    .ack        (ack)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        mode;
    logic [3:0]  sel;
    logic        start;
    logic        dv;
    logic        din;
    logic [15:0] e_q;
    logic [3:0]  e_idx;
    logic        e_busy;
    logic        e_fv;
    logic        e_ack;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic m,
                       input logic [3:0] s, input logic st,
                       input logic v, input logic d);
    rst_n     = r;
    clr       = c;
    mode      = m;
    sel       = s;
    start     = st;
    din_valid = v;
    din       = d;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_q,
                           input logic [3:0] e_idx, input logic e_busy,
                           input logic e_fv, input logic e_ack);
    check({tag, " q"}, 32'(q), 32'(e_q));
    check({tag, " idx"}, 32'(idx), 32'(e_idx));
    check({tag, " busy"}, 32'(busy), 32'(e_busy));
    check({tag, " frame_valid"}, 32'(frame_valid), 32'(e_fv));
    check({tag, " ack"}, 32'(ack), 32'(e_ack));
  endtask

  // Scan one frame; max_gap inserts idle cycles, noisy toggles mode/sel/start.
  task automatic run_frame(input string tag, input logic [15:0] data,
                           input int max_gap, input bit noisy);
    logic [15:0] model;
    logic [15:0] popped;
    int gap;
    drive(1, 1, 0, 4'd0, 0, 0, 0);
    step();
    check_all({tag, " clr"}, 16'h0000, 4'd0, 0, 0, 0);
    drive(1, 0, 1, 4'd0, 1, 1, 1);
    step();
    check_all({tag, " start"}, 16'h0000, 4'd0, 1, 0, 0);
    exp_q.push_back(data);
    model = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        drive(1, 0, noisy ? 1'($urandom_range(1, 0)) : 1'b1,
              noisy ? 4'($urandom_range(15, 0)) : 4'd0, noisy, 0, 1);
        step();
        check_all({tag, " gap"}, model, 4'(i), 1, 0, 0);
      end
      drive(1, 0, noisy ? 1'($urandom_range(1, 0)) : 1'b1,
            noisy ? 4'($urandom_range(15, 0)) : 4'd0, noisy, 1, data[i]);
      step();
      model[i] = data[i];
      if (i < 15) begin
        check_all({tag, " beat"}, model, 4'(i + 1), 1, 0, 0);
      end else begin
        check_all({tag, " last"}, model, 4'd0, 0, 1, 0);
        if (frame_valid) begin
          check({tag, " sb size"}, 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            check({tag, " sb frame"}, 32'(q), 32'(popped));
          end
        end
      end
    end
    // DONE cycle: beat and start must both be ignored
    drive(1, 0, 1, 4'd5, 1, 1, ~data[0]);
    step();
    check_all({tag, " after done"}, data, 4'd0, 0, 0, 0);
    drive(1, 0, 1, 4'd5, 0, 1, ~data[5]);
    step();
    check_all({tag, " idle"}, data, 4'd0, 0, 0, 0);
  endtask

  task automatic run_abort(input string tag, input bit use_rst);
    drive(1, 1, 0, 4'd0, 0, 0, 0);
    step();
    drive(1, 0, 1, 4'd0, 1, 0, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 1, 4'd0, 0, 1, 1);
      step();
    end
    check_all({tag, " partial"}, 16'h007F, 4'd7, 1, 0, 0);
    if (use_rst) drive(0, 0, 1, 4'd0, 0, 1, 1);
    else         drive(1, 1, 1, 4'd0, 0, 1, 1);
    step();
    check_all({tag, " aborted"}, 16'h0000, 4'd0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 4'd0, 0, 1, 1);
      step();
      check_all({tag, " idle"}, 16'h0000, 4'd0, 0, 0, 0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    drive(0, 0, 0, 4'd0, 0, 0, 0);

    //           rst clr mode sel  st dv din   q        idx  bsy fv ack
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 1'b1, 16'h0008, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd12, 1'b0, 1'b1, 1'b1, 16'h1008, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 16'h1000, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 16'h1000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 16'h1000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0, 16'h1000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 16'h8000, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 16'h8000, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd2,  1'b0, 1'b1, 1'b1, 16'h8001, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].rst_n, vecs[v].clr, vecs[v].mode, vecs[v].sel,
            vecs[v].start, vecs[v].dv, vecs[v].din);
      step();
      check_all($sformatf("vec%0d", v), vecs[v].e_q, vecs[v].e_idx,
                vecs[v].e_busy, vecs[v].e_fv, vecs[v].e_ack);
    end

    run_frame("scan", 16'hA5C3, 0, 1'b0);
    run_frame("gapped", 16'hA5C3, 3, 1'b0);
    run_frame("noisy", 16'h3C5A, 2, 1'b1);
    run_abort("abort_clr", 1'b0);
    run_abort("abort_rst", 1'b1);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
